// File: rtl/divider_8_bit_if.sv
// Request/response bundle for the sequential divider: operands and start in, results and status out.
interface divider_8_bit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, A, B,
        input  Q, R, busy, done, div_by_zero
    );

    modport slave (
        input  start, A, B,
        output Q, R, busy, done, div_by_zero
    );
endinterface

// File: rtl/divider_8_bit.sv
// Unsigned restoring divider: one trial subtraction per clock, WIDTH iterations,
// start/busy/done handshake with results held until the next completion.
module divider_8_bit #(
    parameter int WIDTH = 8
) (
    input  logic            CLK,
    input  logic            RST,
    divider_8_bit_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH:0]   r_p;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_dbz;

    logic [WIDTH:0]   w_pshift;
    logic [WIDTH:0]   w_t;
    logic [WIDTH:0]   w_pnext;
    logic [WIDTH-1:0] w_dnext;
    logic             w_last;

    // One restoring step: bring in the next dividend bit, try subtracting the divisor.
    assign w_pshift = {r_p[WIDTH-1:0], r_d[WIDTH-1]};
    assign w_t      = w_pshift - {1'b0, r_b};
    assign w_pnext  = w_t[WIDTH] ? w_pshift : w_t;
    assign w_dnext  = {r_d[WIDTH-2:0], ~w_t[WIDTH]};
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_next = (bus.B == '0) ? S_DONE : S_RUN;
            S_RUN:  if (w_last)    w_next = S_DONE;
            S_DONE:                w_next = S_IDLE;
            default:               w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_p   <= '0;
            r_d   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_q   <= '0;
            r_r   <= '0;
            r_dbz <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_d   <= bus.A;
                        r_b   <= bus.B;
                        r_p   <= '0;
                        r_cnt <= '0;
                        // Divide by zero short-circuits straight to the result.
                        if (bus.B == '0) begin
                            r_q   <= '1;
                            r_r   <= bus.A;
                            r_dbz <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_p   <= w_pnext;
                    r_d   <= w_dnext;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_q   <= w_dnext;
                        r_r   <= w_pnext[WIDTH-1:0];
                        r_dbz <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Q           = r_q;
    assign bus.R           = r_r;
    assign bus.div_by_zero = r_dbz;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_DONE);
endmodule

// File: tb/tb_divider_8_bit.sv
// Directed table plus hand-written handshake/reset sequences for divider_8_bit.
module tb_divider_8_bit;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } vec_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    int   done_cnt;
    logic [W-1:0] prev_q;
    logic [W-1:0] prev_r;

    divider_8_bit_if #(.WIDTH(W)) bus ();

    divider_8_bit #(.WIDTH(W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Issue one op, wait for done, check latency, hold behaviour and results.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
        int  n;
        bit  got;
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        n = 0;
        got = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("busy_after_accept", bus.busy, 1);
                if (b != 0) begin
                    check("q_hold", bus.Q, prev_q);
                    check("r_hold", bus.R, prev_r);
                end
            end
            if (bus.done) got = 1;
        end
        check("latency", n, (b == 0) ? 1 : W + 1);
        check("q", bus.Q, eq);
        check("r", bus.R, er);
        check("dbz", bus.div_by_zero, edbz);
        prev_q = eq;
        prev_r = er;
        @(negedge clk);
        check("done_one_cycle", bus.done, 0);
        check("idle_after_done", bus.busy, 0);
    endtask

    initial begin
        vec_t vecs[$];
        logic [W-1:0] ca, cb, ea, eb;
        int n;
        bit ok;

        n_pass = 0;
        n_total = 0;
        done_cnt = 0;
        prev_q = '0;
        prev_r = '0;

        vecs.push_back('{a:8'd200, b:8'd7,   q:8'd28,  r:8'd4,  dbz:1'b0});
        vecs.push_back('{a:8'd255, b:8'd1,   q:8'd255, r:8'd0,  dbz:1'b0});
        vecs.push_back('{a:8'd255, b:8'd255, q:8'd1,   r:8'd0,  dbz:1'b0});
        vecs.push_back('{a:8'd5,   b:8'd9,   q:8'd0,   r:8'd5,  dbz:1'b0});
        vecs.push_back('{a:8'd77,  b:8'd0,   q:8'd255, r:8'd77, dbz:1'b1});
        vecs.push_back('{a:8'd9,   b:8'd3,   q:8'd3,   r:8'd0,  dbz:1'b0});
        vecs.push_back('{a:8'd0,   b:8'd5,   q:8'd0,   r:8'd0,  dbz:1'b0});
        vecs.push_back('{a:8'd128, b:8'd2,   q:8'd64,  r:8'd0,  dbz:1'b0});
        vecs.push_back('{a:8'd1,   b:8'd255, q:8'd0,   r:8'd1,  dbz:1'b0});
        vecs.push_back('{a:8'd254, b:8'd16,  q:8'd15,  r:8'd14, dbz:1'b0});
        vecs.push_back('{a:8'd0,   b:8'd0,   q:8'd255, r:8'd0,  dbz:1'b1});
        vecs.push_back('{a:8'd100, b:8'd10,  q:8'd10,  r:8'd0,  dbz:1'b0});

        rst = 1'b1;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_q", bus.Q, 0);
        check("rst_r", bus.R, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_dbz", bus.div_by_zero, 0);
        rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);

        // start pulsed mid-operation must be ignored
        done_cnt = 0;
        @(negedge clk);
        bus.A = 8'd100;
        bus.B = 8'd10;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.A = 8'd1;
        bus.B = 8'd1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);
        check("busy_ignore_dones", done_cnt, 1);
        check("busy_ignore_q", bus.Q, 10);
        check("busy_ignore_r", bus.R, 0);
        check("busy_ignore_idle", bus.busy, 0);

        // reset on the 4th RUN edge abandons the op
        @(negedge clk);
        bus.A = 8'd200;
        bus.B = 8'd3;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_q", bus.Q, 0);
        check("midrst_r", bus.R, 0);
        check("midrst_dbz", bus.div_by_zero, 0);
        rst = 1'b0;
        done_cnt = 0;
        repeat (12) @(negedge clk);
        check("midrst_no_done", done_cnt, 0);
        prev_q = '0;
        prev_r = '0;
        run_op(8'd13, 8'd4, 8'd3, 8'd1, 1'b0);

        // start held high: back-to-back random ops, operands changed after each accept
        ca = 8'($urandom_range(0, 255));
        cb = 8'($urandom_range(1, 255));
        @(negedge clk);
        bus.A = ca;
        bus.B = cb;
        bus.start = 1'b1;
        ok = 1;
        for (int i = 0; i < 300 && ok; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("held_accept", bus.busy, 1);
            ea = ca;
            eb = cb;
            ca = 8'($urandom_range(0, 255));
            cb = 8'($urandom_range(1, 255));
            bus.A = ca;
            bus.B = cb;
            n = 1;
            while (!bus.done && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("held_latency", n, W + 1);
            if (n >= 20) ok = 0;
            check("held_q", bus.Q, ea / eb);
            check("held_r", bus.R, ea % eb);
            @(posedge clk);
            @(negedge clk);
            check("held_idle_gap", bus.busy, 0);
        end
        bus.start = 1'b0;
        repeat (12) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
